// File: rtl/mem_lsu_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } sl_type_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  function automatic logic is_load(input sl_type_e t);
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(input sl_type_e t);
    return t inside {SB, SH, SW};
  endfunction

  function automatic logic is_half(input sl_type_e t);
    return t inside {LH, LHU, SH};
  endfunction

  function automatic logic is_word(input sl_type_e t);
    return t inside {LW, SW};
  endfunction

  function automatic logic is_misaligned(input sl_type_e t, input logic [1:0] a);
    return (is_half(t) && a[0]) || (is_word(t) && (a != 2'b00));
  endfunction

  // Misaligned halves/words are snapped down to their natural boundary.
  function automatic logic [31:0] align_addr(input sl_type_e t, input logic [31:0] a);
    logic [31:0] r;
    r = a;
    if (is_half(t)) r[0] = 1'b0;
    if (is_word(t)) r[1:0] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/grant/rvalid interface between the LSU (master) and memory (slave).
interface mem_lsu_if;

  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  modport master (
    output dbus_req_o,
    output dbus_we_o,
    output dbus_addr_o,
    output dbus_be_o,
    output dbus_wdata_o,
    input  dbus_gnt_i,
    input  dbus_rvalid_i,
    input  dbus_rdata_i
  );

  modport slave (
    input  dbus_req_o,
    input  dbus_we_o,
    input  dbus_addr_o,
    input  dbus_be_o,
    input  dbus_wdata_o,
    output dbus_gnt_i,
    output dbus_rvalid_i,
    output dbus_rdata_i
  );

endinterface

// File: rtl/mem_lsu_load_ext.sv
// Load lane select and sign/zero extension of a raw bus word into a WB value.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  sl_type_e    sl_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[8*byte_off +: 8];
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (sl_type)
      LB:      data = {{24{sel_byte[7]}}, sel_byte};
      LBU:     data = {24'b0, sel_byte};
      LH:      data = {{16{sel_half[15]}}, sel_half};
      LHU:     data = {16'b0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one pipeline access -> one req/gnt/rvalid bus transaction.
// Optional LSU_MISALIGN_EXC_EN: misaligned accesses complete at once with misalign_o instead of issuing.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic        dram_we_i,
  input  sl_type_e    sl_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  mem_lsu_if.master   dbus
);

  localparam int            CW      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic          WD_EN   = (WAIT_TIMEOUT > 0);

  lsu_state_e    state_q, state_d;
  sl_type_e      type_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   load_data, lane_wdata;
  logic [3:0]    lane_be;
  logic [CW-1:0] wd_cnt_q;
  logic          err_q, access, wd_hit, q_is_load, in_req;
`ifdef LSU_MISALIGN_EXC_EN
  logic          mis_now, mis_q;
`endif

  assign access    = mem_valid_i && (dram_we_i ? is_store(sl_type_i) : is_load(sl_type_i));
  assign wd_hit    = WD_EN && (wd_cnt_q == WD_LAST);
  assign q_is_load = is_load(type_q);
  assign in_req    = (state_q == REQ);
`ifdef LSU_MISALIGN_EXC_EN
  assign mis_now   = is_misaligned(sl_type_i, addr_i[1:0]);
`endif

  lsu_load_ext u_load_ext (
    .sl_type  (type_q),
    .byte_off (addr_q[1:0]),
    .rdata    (dbus.dbus_rdata_i),
    .data     (load_data)
  );

  // Next state and the combinational stall; the response that completes a phase wins over the watchdog.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall_o = 1'b1;
`ifdef LSU_MISALIGN_EXC_EN
          state_d = mis_now ? DONE : REQ;
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dbus.dbus_gnt_i) begin
          if (!q_is_load || dbus.dbus_rvalid_i) state_d = DONE;
          else                                  state_d = WAIT;
        end else if (wd_hit) begin
          state_d = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dbus.dbus_rvalid_i || wd_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      type_q   <= NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (access) begin
            type_q   <= sl_type_i;
            addr_q   <= align_addr(sl_type_i, addr_i);
            wdata_q  <= wdata_i;
            rdata_q  <= '0;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            mis_q    <= mis_now;
`endif
          end
        end
        REQ: begin
          if (dbus.dbus_gnt_i) begin
            wd_cnt_q <= '0;
            if (q_is_load && dbus.dbus_rvalid_i) rdata_q <= load_data;
          end else if (wd_hit) begin
            err_q <= 1'b1;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (dbus.dbus_rvalid_i) rdata_q  <= load_data;
          else if (wd_hit)        err_q    <= 1'b1;
          else                    wd_cnt_q <= wd_cnt_q + 1'b1;
        end
        DONE: begin
          err_q <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
          mis_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Store lane steering: data is replicated across lanes, byte enables pick the active one(s).
  always_comb begin
    lane_be    = 4'b0001 << addr_q[1:0];
    lane_wdata = {4{wdata_q[7:0]}};
    if (is_word(type_q)) begin
      lane_be    = 4'b1111;
      lane_wdata = wdata_q;
    end else if (is_half(type_q)) begin
      lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{wdata_q[15:0]}};
    end
  end

  assign dbus.dbus_req_o   = in_req;
  assign dbus.dbus_we_o    = in_req && !q_is_load;
  assign dbus.dbus_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'b0;
  assign dbus.dbus_be_o    = in_req ? lane_be : 4'b0000;
  assign dbus.dbus_wdata_o = (in_req && !q_is_load) ? lane_wdata : 32'b0;

  assign done_o    = (state_q == DONE);
  assign bus_err_o = done_o && err_q;
  assign rdata_o   = rdata_q;
`ifdef LSU_MISALIGN_EXC_EN
  assign misalign_o = done_o && mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a cycle-level transaction model.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mem_valid, dram_we;
  sl_type_e    sl_type;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, bus_err, misalign;

  logic        w_valid, w_we;
  sl_type_e    w_sl_type;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic        w_stall, w_done, w_bus_err, w_misalign;

  mem_lsu_if bus ();
  mem_lsu_if w_bus ();

  mem_lsu #(.WAIT_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid_i(mem_valid), .dram_we_i(dram_we),
    .sl_type_i(sl_type), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
    .done_o(done), .rdata_o(rdata), .bus_err_o(bus_err), .misalign_o(misalign),
    .dbus(bus)
  );

  mem_lsu #(.WAIT_TIMEOUT(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .mem_valid_i(w_valid), .dram_we_i(w_we),
    .sl_type_i(w_sl_type), .addr_i(w_addr), .wdata_i(w_wdata), .stall_o(w_stall),
    .done_o(w_done), .rdata_o(w_rdata), .bus_err_o(w_bus_err), .misalign_o(w_misalign),
    .dbus(w_bus)
  );

  int total = 0;
  int bad   = 0;

  sl_type_e load_types[5]  = '{LB, LH, LW, LBU, LHU};
  sl_type_e store_types[3] = '{SB, SH, SW};

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit tb_is_load(input sl_type_e t);
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit tb_is_store(input sl_type_e t);
    return t inside {SB, SH, SW};
  endfunction

  function automatic int size_of(input sl_type_e t);
    case (t)
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input sl_type_e t, input logic [31:0] ea, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * ea[1:0]);
    case (t)
      LB:      v = {{24{v[7]}}, v[7:0]};
      LBU:     v = {24'b0, v[7:0]};
      LH:      v = {{16{v[15]}}, v[15:0]};
      LHU:     v = {16'b0, v[15:0]};
      default: v = word;
    endcase
    return v;
  endfunction

  // One access end to end: drive the pipeline side, play a scheduled memory, check every cycle.
  task automatic apply_stimulus(input string name, input logic v, input logic we, input sl_type_e t,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] word,
                                input int gnt_dly, input int rv_dly);
    bit          is_acc, ld, mis, mis_exc, issue, real_rv, stale;
    bit          exp_req, exp_stall, exp_done;
    int          sz, g, done_cyc, last;
    logic [31:0] ea, exp_wd;
    logic [3:0]  exp_be;
    is_acc = v && (we ? tb_is_store(t) : tb_is_load(t));
    ld     = tb_is_load(t);
    sz     = size_of(t);
    ea     = a - (a % 32'(sz));
    mis    = (a % 32'(sz)) != 0;
`ifdef LSU_MISALIGN_EXC_EN
    mis_exc = is_acc && mis;
`else
    mis_exc = 1'b0;
`endif
    issue  = is_acc && !mis_exc;
    exp_be = 4'(((1 << sz) - 1) << ea[1:0]);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = d[8*(i % sz) +: 8];
    g = gnt_dly + 1;
    if (!is_acc)      done_cyc = -1;
    else if (mis_exc) done_cyc = 1;
    else if (!ld)     done_cyc = g + 1;
    else              done_cyc = g + rv_dly + 1;
    last = is_acc ? done_cyc + 1 : 2;

    for (int cyc = 0; cyc <= last; cyc++) begin
      if (cyc == 0) begin
        mem_valid = v; dram_we = we; sl_type = t; addr = a; wdata = d;
      end
      if (is_acc && cyc == done_cyc + 1) mem_valid = 1'b0;
      real_rv = issue && ld && (cyc == g + rv_dly);
      stale   = (cyc == 0) || !is_acc || (cyc >= done_cyc);
      bus.dbus_gnt_i    = stale || (issue && cyc == g);
      bus.dbus_rvalid_i = stale || real_rv;
      bus.dbus_rdata_i  = real_rv ? word : $urandom();
      @(negedge clk);
      exp_req   = issue && cyc >= 1 && cyc <= g;
      exp_stall = is_acc && cyc < done_cyc;
      exp_done  = is_acc && cyc == done_cyc;
      check_output($sformatf("%s c%0d req", name, cyc), bus.dbus_req_o, exp_req);
      check_output($sformatf("%s c%0d stall", name, cyc), stall, exp_stall);
      check_output($sformatf("%s c%0d done", name, cyc), done, exp_done);
      check_output($sformatf("%s c%0d bus_err", name, cyc), bus_err, 0);
      check_output($sformatf("%s c%0d misalign", name, cyc), misalign, exp_done && mis_exc);
      if (exp_req) begin
        check_output($sformatf("%s c%0d addr", name, cyc), bus.dbus_addr_o, {ea[31:2], 2'b00});
        check_output($sformatf("%s c%0d be", name, cyc), bus.dbus_be_o, exp_be);
        check_output($sformatf("%s c%0d we", name, cyc), bus.dbus_we_o, !ld);
        if (!ld) check_output($sformatf("%s c%0d wdata", name, cyc), bus.dbus_wdata_o, exp_wd);
      end
      if (exp_done && ld)
        check_output($sformatf("%s c%0d rdata", name, cyc), rdata, mis_exc ? 32'b0 : model_load(t, ea, word));
      @(posedge clk);
      #1;
    end
    mem_valid = 1'b0;
    bus.dbus_gnt_i = 1'b0;
    bus.dbus_rvalid_i = 1'b0;
  endtask

  task automatic reset_mid_test();
    mem_valid = 1'b1; dram_we = 1'b0; sl_type = LW; addr = 32'h200; wdata = 32'b0;
    bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    bus.dbus_gnt_i = 1'b1;
    @(negedge clk);
    check_output("rstmid req", bus.dbus_req_o, 1);
    @(posedge clk); #1;
    bus.dbus_gnt_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_output("rstmid stall wait", stall, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_valid = 1'b0;
    bus.dbus_rvalid_i = 1'b1; bus.dbus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    check_output("rstmid req after", bus.dbus_req_o, 0);
    check_output("rstmid stall after", stall, 0);
    check_output("rstmid done after", done, 0);
    @(posedge clk); #1;
    bus.dbus_rvalid_i = 1'b0;
    @(negedge clk);
    check_output("rstmid done late", done, 0);
    check_output("rstmid rdata", rdata, 0);
    @(posedge clk); #1;
  endtask

  // Watchdog instance: never answers in REQ (or grants but never returns data), then late responses.
  task automatic wd_test(input string name, input bit use_gnt);
    int done_cyc;
    bit exp_req;
    done_cyc = use_gnt ? 6 : 5;
    for (int cyc = 0; cyc <= done_cyc + 2; cyc++) begin
      if (cyc == 0) begin
        w_valid = 1'b1; w_we = 1'b0; w_sl_type = LW; w_addr = 32'h40; w_wdata = 32'b0;
      end
      if (cyc == done_cyc + 1) w_valid = 1'b0;
      w_bus.dbus_gnt_i    = use_gnt && cyc == 1;
      w_bus.dbus_rvalid_i = (cyc >= done_cyc);
      w_bus.dbus_rdata_i  = $urandom();
      @(negedge clk);
      exp_req = use_gnt ? (cyc == 1) : (cyc >= 1 && cyc <= 4);
      check_output($sformatf("%s c%0d req", name, cyc), w_bus.dbus_req_o, exp_req);
      check_output($sformatf("%s c%0d stall", name, cyc), w_stall, cyc < done_cyc);
      check_output($sformatf("%s c%0d done", name, cyc), w_done, cyc == done_cyc);
      check_output($sformatf("%s c%0d bus_err", name, cyc), w_bus_err, cyc == done_cyc);
      if (cyc == done_cyc) check_output($sformatf("%s c%0d rdata", name, cyc), w_rdata, 0);
      @(posedge clk);
      #1;
    end
    w_bus.dbus_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, word;
    sl_type_e    t;
    bit          we;
    int          r;
    rst_n = 1'b0;
    mem_valid = 1'b0; dram_we = 1'b0; sl_type = NONE; addr = '0; wdata = '0;
    w_valid = 1'b0; w_we = 1'b0; w_sl_type = NONE; w_addr = '0; w_wdata = '0;
    bus.dbus_gnt_i = 1'b0; bus.dbus_rvalid_i = 1'b0; bus.dbus_rdata_i = '0;
    w_bus.dbus_gnt_i = 1'b0; w_bus.dbus_rvalid_i = 1'b0; w_bus.dbus_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset stall", stall, 0);
    check_output("reset done", done, 0);
    check_output("reset rdata", rdata, 0);
    check_output("reset bus_err", bus_err, 0);
    check_output("reset misalign", misalign, 0);
    check_output("reset req", bus.dbus_req_o, 0);
    check_output("reset be", bus.dbus_be_o, 0);
    check_output("reset wd req", w_bus.dbus_req_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apply_stimulus("sw",      1, 1, SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0);
    apply_stimulus("sb",      1, 1, SB,  32'h103, 32'h000000A5, 32'h0,        0, 0);
    apply_stimulus("sh",      1, 1, SH,  32'h102, 32'h00001234, 32'h0,        1, 0);
    apply_stimulus("lb",      1, 0, LB,  32'h3,   32'h0,        32'h80FF7F01, 0, 1);
    apply_stimulus("lbu",     1, 0, LBU, 32'h3,   32'h0,        32'h80FF7F01, 0, 1);
    apply_stimulus("lh",      1, 0, LH,  32'h2,   32'h0,        32'h80FF7F01, 0, 0);
    apply_stimulus("lhu",     1, 0, LHU, 32'h0,   32'h0,        32'h80FF7F01, 2, 2);
    apply_stimulus("lw_slow", 1, 0, LW,  32'h100, 32'h0,        32'hCAFEF00D, 5, 3);
    apply_stimulus("lw_mis",  1, 0, LW,  32'h101, 32'h0,        32'h11223344, 0, 1);
    apply_stimulus("sh_mis",  1, 1, SH,  32'h205, 32'h0000BEEF, 32'h0,        0, 0);
    apply_stimulus("nonacc",  1, 1, LW,  32'h10,  32'h0,        32'h0,        0, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom(); d = $urandom(); word = $urandom();
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0:       apply_stimulus("rnd_nv", 0, 0, load_types[$urandom_range(0, 4)], a, d, word, 0, 0);
          1:       apply_stimulus("rnd_none", 1, 1'($urandom_range(0, 1)), NONE, a, d, word, 0, 0);
          default: apply_stimulus("rnd_mix", 1, 1, load_types[$urandom_range(0, 4)], a, d, word, 0, 0);
        endcase
      end else begin
        we = (r > 5);
        t  = we ? store_types[$urandom_range(0, 2)] : load_types[$urandom_range(0, 4)];
        apply_stimulus($sformatf("rnd%0d", n), 1, we, t, a, d, word,
                       $urandom_range(0, 4), $urandom_range(0, 3));
      end
    end

    reset_mid_test();
    wd_test("wd_req", 1'b0);
    wd_test("wd_wait", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
